// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Holds the fetch FSM state encoding, IR byte-select codes and defaults.
package fetch_ctrl_pkg;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_FETCH_LO = 2'd1;
   localparam logic [1:0] ST_FETCH_HI = 2'd2;
   localparam logic [1:0] ST_VALID    = 2'd3;

   typedef enum logic [1:0] {
      IDLE     = ST_IDLE,
      FETCH_LO = ST_FETCH_LO,
      FETCH_HI = ST_FETCH_HI,
      VALID    = ST_VALID
   } fetch_state_e;

   localparam logic IR_LH_LOW  = 1'b0;
   localparam logic IR_LH_HIGH = 1'b1;

   localparam int unsigned TIMEOUT_CYCLES_DEF = 16;
   localparam int unsigned COUNT_W_DEF        = 16;

endpackage

// File: rtl/instruction_fetch_controller_if.sv
// Fetch controller bus: memory port, IR strobes, PC strobe, decoder handshake.
// master = fetch controller side, slave = memory/IR/decoder environment side.
interface instruction_fetch_controller_if
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned COUNT_W = COUNT_W_DEF
);

   logic               FetchReq;
   logic [7:0]         MemData;
   logic               MemReady;
   logic               InstrTaken;
   logic               MemRead;
   logic               PCInc;
   logic               IRWrite;
   logic               IRLH;
   logic [7:0]         IRData;
   logic               InstrValid;
   logic               Busy;
   logic               FetchError;
   logic [COUNT_W-1:0] InstrCount;

   modport master (
      input  FetchReq, MemData, MemReady, InstrTaken,
      output MemRead, PCInc, IRWrite, IRLH, IRData,
      output InstrValid, Busy, FetchError, InstrCount
   );

   modport slave (
      output FetchReq, MemData, MemReady, InstrTaken,
      input  MemRead, PCInc, IRWrite, IRLH, IRData,
      input  InstrValid, Busy, FetchError, InstrCount
   );

endinterface

// File: rtl/fetch_wait_counter.sv
// Memory wait-state counter used by the optional fetch timeout.
// Ports: clk, rst (sync, high), clr, en, tc (count == LIMIT-1).
module fetch_wait_counter
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned LIMIT = TIMEOUT_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [7:0] LAST = 8'(LIMIT - 1);

   logic [7:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 8'd1;
      end
   end

   assign tc = (cnt == LAST);

endmodule

// File: rtl/instruction_fetch_controller.sv
// Fetches a 16-bit instruction into the IR as two byte reads (low, high)
// and hands it to the decoder with a valid/taken handshake.
// Ports: Clock, Reset (sync, high), bus (master modport: FetchReq, MemData,
// MemReady, InstrTaken in; MemRead, PCInc, IRWrite, IRLH, IRData,
// InstrValid, Busy, FetchError, InstrCount out).
// Optional: define FETCH_TIMEOUT_EN to abort fetches stuck in wait states.
module instruction_fetch_controller
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter int unsigned COUNT_W        = COUNT_W_DEF
) (
   input  logic                           Clock,
   input  logic                           Reset,
   instruction_fetch_controller_if.master bus
);

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be within 2..255");
   end

   fetch_state_e       state;
   fetch_state_e       state_nxt;
   logic [COUNT_W-1:0] count;
   logic               in_fetch;
   logic               accept;
   logic               timeout;
   logic               fetch_error;

   // Reset masks every strobe so a reset cycle never writes the IR
   // or bumps the PC, even mid-fetch.
   assign in_fetch = ((state == FETCH_LO) || (state == FETCH_HI)) && !Reset;
   assign accept   = in_fetch && bus.MemReady;

`ifdef FETCH_TIMEOUT_EN
   logic wait_tc;

   // Held clear outside fetch states, so it starts at zero on entry.
   fetch_wait_counter #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_wait (
      .clk (Clock),
      .rst (Reset),
      .clr (!in_fetch || bus.MemReady),
      .en  (in_fetch && !bus.MemReady),
      .tc  (wait_tc)
   );

   assign timeout = in_fetch && !bus.MemReady && wait_tc;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         fetch_error <= 1'b0;
      end else begin
         fetch_error <= timeout;
      end
   end
`else
   assign timeout     = 1'b0;
   assign fetch_error = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (bus.FetchReq) state_nxt = FETCH_LO;
         end
         FETCH_LO: begin
            if (bus.MemReady)  state_nxt = FETCH_HI;
            else if (timeout)  state_nxt = IDLE;
         end
         FETCH_HI: begin
            if (bus.MemReady)  state_nxt = VALID;
            else if (timeout)  state_nxt = IDLE;
         end
         VALID: begin
            if (bus.InstrTaken)
               state_nxt = bus.FetchReq ? FETCH_LO : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= IDLE;
         count <= '0;
      end else begin
         state <= state_nxt;
         if (accept && (state == FETCH_HI))
            count <= count + 1'b1;
      end
   end

   assign bus.MemRead    = in_fetch;
   assign bus.Busy       = in_fetch;
   assign bus.IRWrite    = accept;
   assign bus.PCInc      = accept;
   assign bus.IRLH       = ((state == FETCH_HI) && !Reset) ? IR_LH_HIGH
                                                           : IR_LH_LOW;
   assign bus.IRData     = bus.MemData;
   assign bus.InstrValid = (state == VALID) && !Reset;
   assign bus.FetchError = fetch_error && !Reset;
   assign bus.InstrCount = count;

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Self-checking bench for instruction_fetch_controller.
// Holds an IR model, a behavioural reference and directed plus random stimulus.
module tb_instruction_fetch_controller;
   import fetch_ctrl_pkg::*;

   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [7:0] lob = 8'h00;
   logic [7:0] hib = 8'h00;

   instruction_fetch_controller_if #(.COUNT_W(16)) bus();

   instruction_fetch_controller #(
      .TIMEOUT_CYCLES (TO),
      .COUNT_W        (16)
   ) dut (
      .Clock (clk),
      .Reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Memory returns the byte matching the half being fetched.
   assign bus.MemData = bus.IRLH ? hib : lob;

   // Physical IR, written only by the DUT strobes; not reset.
   logic [15:0] ir = 16'h2367;
   always @(posedge clk) begin
      if (bus.IRWrite) begin
         if (bus.IRLH) ir[15:8] <= bus.IRData;
         else          ir[7:0]  <= bus.IRData;
      end
   end

   int n_chk = 0;
   int n_fail = 0;
   int pcinc_n = 0;
   bit chk_en = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a fetch in progress knows which half it wants next;
   // a held instruction waits for the decoder.
   bit          m_fetch = 0;
   bit          m_hi = 0;
   bit          m_hold = 0;
   bit          m_err = 0;
   int          m_wait = 0;
   logic [15:0] m_cnt = '0;
   logic [15:0] m_ir = 16'h2367;

   always @(posedge clk) begin
      if (rst) begin
         m_fetch = 0; m_hold = 0; m_err = 0; m_wait = 0; m_cnt = '0;
      end else begin
         m_err = 0;
         if (m_fetch) begin
            if (bus.MemReady) begin
               m_wait = 0;
               if (!m_hi) begin
                  m_ir[7:0] = lob;
                  m_hi = 1;
               end else begin
                  m_ir[15:8] = hib;
                  m_fetch = 0;
                  m_hold = 1;
                  m_cnt = m_cnt + 16'd1;
               end
            end else begin
`ifdef FETCH_TIMEOUT_EN
               if (m_wait == TO - 1) begin
                  m_fetch = 0;
                  m_err = 1;
               end else begin
                  m_wait++;
               end
`endif
            end
         end else if (m_hold) begin
            if (bus.InstrTaken) begin
               m_hold = 0;
               if (bus.FetchReq) begin
                  m_fetch = 1; m_hi = 0; m_wait = 0;
               end
            end
         end else if (bus.FetchReq) begin
            m_fetch = 1; m_hi = 0; m_wait = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (bus.PCInc) pcinc_n++;
      if (chk_en) begin
         check("MemRead", 32'(bus.MemRead), 32'(m_fetch && !rst));
         check("Busy", 32'(bus.Busy), 32'(m_fetch && !rst));
         check("IRWrite", 32'(bus.IRWrite),
               32'(m_fetch && !rst && bus.MemReady));
         check("PCInc", 32'(bus.PCInc),
               32'(m_fetch && !rst && bus.MemReady));
         check("IRLH", 32'(bus.IRLH), 32'(m_fetch && m_hi && !rst));
         check("InstrValid", 32'(bus.InstrValid), 32'(m_hold && !rst));
         check("FetchError", 32'(bus.FetchError), 32'(m_err && !rst));
         check("IRData", 32'(bus.IRData), 32'(bus.MemData));
         check("InstrCount", 32'(bus.InstrCount), 32'(m_cnt));
         check("IROut", 32'(ir), 32'(m_ir));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int n;
   int pc0;

   initial begin
      bus.FetchReq = 0;
      bus.MemReady = 0;
      bus.InstrTaken = 0;
      rst = 1;
      step();
      chk_en = 1;
      step();
      check("rst_valid", 32'(bus.InstrValid), 32'd0);
      check("rst_count", 32'(bus.InstrCount), 32'd0);
      rst = 0;

      // Basic fetch, MemReady always high.
      lob = 8'h15; hib = 8'h23;
      bus.MemReady = 1;
      bus.FetchReq = 1;
      pc0 = pcinc_n;
      n = 0;
      while (n < 10) begin
         step();
         n++;
         bus.FetchReq = 0;
         if (bus.InstrValid) break;
      end
      check("t1_latency", 32'(n), 32'd3);
      check("t1_ir", 32'(ir), 32'h2315);
      check("t1_pcinc", 32'(pcinc_n - pc0), 32'd2);
      check("t1_count", 32'(bus.InstrCount), 32'd1);
      bus.InstrTaken = 1;
      step();
      bus.InstrTaken = 0;

      // Wait states: 3 in low half, 2 in high half.
      lob = 8'hAB; hib = 8'hCD;
      bus.MemReady = 0;
      bus.FetchReq = 1;
      step();
      bus.FetchReq = 0;
      repeat (3) step();
      bus.MemReady = 1;
      step();
      bus.MemReady = 0;
      repeat (2) step();
      check("t2_notyet", 32'(bus.InstrValid), 32'd0);
      bus.MemReady = 1;
      step();
      check("t2_valid", 32'(bus.InstrValid), 32'd1);
      check("t2_ir", 32'(ir), 32'hCDAB);

      // Back-to-back fetch straight out of VALID.
      lob = 8'h01; hib = 8'h80;
      bus.InstrTaken = 1;
      bus.FetchReq = 1;
      step();
      bus.InstrTaken = 0;
      bus.FetchReq = 0;
      check("t3_busy", 32'(bus.Busy), 32'd1);
      repeat (2) step();
      check("t3_valid", 32'(bus.InstrValid), 32'd1);
      check("t3_ir", 32'(ir), 32'h8001);
      check("t3_count", 32'(bus.InstrCount), 32'd3);

      // Request without taken is ignored while holding.
      pc0 = pcinc_n;
      bus.FetchReq = 1;
      repeat (5) begin
         step();
         check("t5_memread", 32'(bus.MemRead), 32'd0);
         check("t5_valid", 32'(bus.InstrValid), 32'd1);
      end
      check("t5_pcinc", 32'(pcinc_n - pc0), 32'd0);
      bus.FetchReq = 0;
      bus.InstrTaken = 1;
      step();
      bus.InstrTaken = 0;

      // Reset during the high-byte fetch.
      lob = 8'h5A; hib = 8'hC3;
      bus.MemReady = 1;
      bus.FetchReq = 1;
      step();
      bus.FetchReq = 0;
      step();
      check("t4_inhi", 32'(bus.IRLH), 32'd1);
      rst = 1;
      step();
      rst = 0;
      check("t4_busy", 32'(bus.Busy), 32'd0);
      check("t4_count", 32'(bus.InstrCount), 32'd0);
      check("t4_ir", 32'(ir), 32'h805A);
      step();
      check("t4_idle", 32'(bus.MemRead), 32'd0);

`ifdef FETCH_TIMEOUT_EN
      // Stall the low byte until the fetch aborts.
      bus.MemReady = 0;
      bus.FetchReq = 1;
      step();
      bus.FetchReq = 0;
      repeat (3) begin
         step();
         check("t6_wait", 32'(bus.Busy), 32'd1);
         check("t6_noerr", 32'(bus.FetchError), 32'd0);
      end
      step();
      check("t6_err", 32'(bus.FetchError), 32'd1);
      check("t6_idle", 32'(bus.Busy), 32'd0);
      step();
      check("t6_errgone", 32'(bus.FetchError), 32'd0);
      check("t6_count", 32'(bus.InstrCount), 32'd0);
`endif

      // Random traffic against the reference.
      for (int i = 0; i < 3000; i++) begin
         bus.FetchReq   = ($urandom_range(0, 1) == 1);
         bus.MemReady   = ($urandom_range(0, 9) < 7);
         bus.InstrTaken = ($urandom_range(0, 9) < 4);
         lob = 8'($urandom);
         hib = 8'($urandom);
         rst = ($urandom_range(0, 199) == 0);
         step();
      end
      rst = 0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
